// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase: single-clock tick-enable timebase and PAUSE/RUN/ADJUST mode FSM (macro TIMEBASE_FAST_SIM_EN selects short fixed divisors)
module stopwatch_timebase #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int ADJ_HZ   = 2,
    parameter int SCAN_HZ  = 500,
    parameter int BLINK_HZ = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_toggle,
    input  logic       adj,
    input  logic       clr,
    output logic       count_en,
    output logic       tick_1hz,
    output logic       tick_adj,
    output logic       tick_scan,
    output logic       blink,
    output logic [1:0] state
);
`ifdef TIMEBASE_FAST_SIM_EN
    localparam int DIV_1HZ  = 16;
    localparam int DIV_ADJ  = 8;
    localparam int DIV_SCAN = 2;
    localparam int DIV_BLK  = 4;
    localparam bit EXACT    = 1'b1;
`else
    localparam int DIV_1HZ  = CLK_HZ;
    localparam int DIV_ADJ  = (ADJ_HZ > 0) ? CLK_HZ / ADJ_HZ : 0;
    localparam int DIV_SCAN = (SCAN_HZ > 0) ? CLK_HZ / SCAN_HZ : 0;
    localparam int DIV_BLK  = (BLINK_HZ > 0) ? CLK_HZ / (2 * BLINK_HZ) : 0;
    localparam bit EXACT    = (DIV_ADJ * ADJ_HZ == CLK_HZ) && (DIV_SCAN * SCAN_HZ == CLK_HZ)
                              && (DIV_BLK * 2 * BLINK_HZ == CLK_HZ);
`endif
    localparam int W_1HZ  = (DIV_1HZ > 2) ? $clog2(DIV_1HZ) : 1;
    localparam int W_ADJ  = (DIV_ADJ > 2) ? $clog2(DIV_ADJ) : 1;
    localparam int W_SCAN = (DIV_SCAN > 2) ? $clog2(DIV_SCAN) : 1;
    localparam int W_BLK  = (DIV_BLK > 2) ? $clog2(DIV_BLK) : 1;
    localparam logic [W_1HZ-1:0]  MAX_1HZ  = W_1HZ'(DIV_1HZ - 1);
    localparam logic [W_ADJ-1:0]  MAX_ADJ  = W_ADJ'(DIV_ADJ - 1);
    localparam logic [W_SCAN-1:0] MAX_SCAN = W_SCAN'(DIV_SCAN - 1);
    localparam logic [W_BLK-1:0]  MAX_BLK  = W_BLK'(DIV_BLK - 1);

    if (DIV_1HZ < 2 || DIV_ADJ < 2 || DIV_SCAN < 2 || DIV_BLK < 2 || !EXACT) begin : g_bad_div
        $fatal(1, "stopwatch_timebase: every divisor must be an integer >= 2");
    end

    typedef enum logic [1:0] {PAUSE = 2'b00, RUN = 2'b01, ADJUST = 2'b10} state_t;

    state_t            cur, nxt;
    logic [W_1HZ-1:0]  cnt_1hz;
    logic [W_ADJ-1:0]  cnt_adj;
    logic [W_SCAN-1:0] cnt_scan;
    logic [W_BLK-1:0]  cnt_blk;

    wire run_now   = (cur == RUN);
    wire adj_now   = (cur == ADJUST);
    wire wrap_1hz  = (cnt_1hz == MAX_1HZ);
    wire wrap_adj  = (cnt_adj == MAX_ADJ);
    wire enter_adj = (nxt == ADJUST) && !adj_now;

    assign state = cur;

    // next mode: adj level dominates, leaving ADJUST or clr parks in PAUSE, run_toggle flips PAUSE/RUN; the unused code falls to PAUSE
    always_comb begin
        nxt = adj ? ADJUST
            : (adj_now || clr) ? PAUSE
            : run_toggle ? (run_now ? PAUSE : RUN)
            : (run_now ? RUN : PAUSE);
    end

    // mode register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= PAUSE;
        else        cur <= nxt;
    end

    // 1 Hz phase advances only in RUN so a pause keeps the sub-second position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_1hz  <= '0;
            tick_1hz <= 1'b0;
        end else begin
            tick_1hz <= run_now && wrap_1hz;
            if (clr)          cnt_1hz <= '0;
            else if (run_now) cnt_1hz <= wrap_1hz ? '0 : cnt_1hz + 1'b1;
        end
    end

    // adjust phase restarts on each entry into ADJUST so the first step is a full period away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_adj  <= '0;
            tick_adj <= 1'b0;
        end else begin
            tick_adj <= adj_now && wrap_adj;
            if (clr || enter_adj) cnt_adj <= '0;
            else if (adj_now)     cnt_adj <= wrap_adj ? '0 : cnt_adj + 1'b1;
        end
    end

    // count enable follows the tick of the mode that was active when the tick was generated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_en <= 1'b0;
        else        count_en <= (run_now && wrap_1hz) || (adj_now && wrap_adj);
    end

    // free-running display scan tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_scan  <= '0;
            tick_scan <= 1'b0;
        end else begin
            tick_scan <= (cnt_scan == MAX_SCAN);
            cnt_scan  <= (cnt_scan == MAX_SCAN) ? '0 : cnt_scan + 1'b1;
        end
    end

    // free-running blink square wave, one toggle per divider wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_blk <= '0;
            blink   <= 1'b0;
        end else begin
            blink   <= (cnt_blk == MAX_BLK) ? ~blink : blink;
            cnt_blk <= (cnt_blk == MAX_BLK) ? '0 : cnt_blk + 1'b1;
        end
    end
endmodule

// File: tb/tb_stopwatch_timebase.sv
// tb_stopwatch_timebase: randomized scoreboard bench for stopwatch_timebase against an arithmetic reference model
module tb_stopwatch_timebase;
    localparam int CLK_HZ   = 1000;
    localparam int ADJ_HZ   = 2;
    localparam int SCAN_HZ  = 250;
    localparam int BLINK_HZ = 4;
    localparam int D1 = CLK_HZ;
    localparam int DA = CLK_HZ / ADJ_HZ;
    localparam int DS = CLK_HZ / SCAN_HZ;
    localparam int DB = CLK_HZ / (2 * BLINK_HZ);

    typedef struct packed {
        logic [1:0] st;
        logic       ce;
        logic       t1;
        logic       ta;
        logic       ts;
        logic       bl;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_toggle = 1'b0;
    logic       adj = 1'b0;
    logic       clr = 1'b0;
    logic       count_en, tick_1hz, tick_adj, tick_scan, blink;
    logic [1:0] state;

    obs_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   seen_1hz = 0;
    int   seen_adj = 0;
    int   seen_ce = 0;

    always #5 clk = ~clk;

    stopwatch_timebase #(
        .CLK_HZ(CLK_HZ), .ADJ_HZ(ADJ_HZ), .SCAN_HZ(SCAN_HZ), .BLINK_HZ(BLINK_HZ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run_toggle(run_toggle), .adj(adj), .clr(clr),
        .count_en(count_en), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .tick_scan(tick_scan), .blink(blink), .state(state)
    );

    function automatic obs_t sample();
        obs_t o;
        o = {state, count_en, tick_1hz, tick_adj, tick_scan, blink};
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s @%0t: got %b expected %b (state,count_en,tick_1hz,tick_adj,tick_scan,blink)",
                     name, $time, got, want);
        end
    endtask

    task automatic check_seen(input string name, input int got, input int least);
        compared++;
        if (got < least) begin
            mismatched++;
            $display("FAIL %s: saw %0d events, need at least %0d", name, got, least);
        end
    endtask

    // reference model: n edges since reset release, RUN/ADJUST cycles elapsed since last clear/entry
    initial begin : model
        int   n, st, nst, run_ph, adj_ph;
        obs_t e;
        n = 0; st = 0; run_ph = 0; adj_ph = 0;
        forever begin
            @(posedge clk);
            e = '0;
            if (!rst_n) begin
                n = 0; st = 0; run_ph = 0; adj_ph = 0;
            end else begin
                n++;
                if (st == 1) begin run_ph++; e.t1 = (run_ph % D1 == 0); end
                if (st == 2) begin adj_ph++; e.ta = (adj_ph % DA == 0); end
                e.ce = (st == 1) ? e.t1 : (st == 2) ? e.ta : 1'b0;
                e.ts = (n % DS == 0);
                e.bl = ((n / DB) % 2) == 1;
                if (adj)                 nst = 2;
                else if (st == 2 || clr) nst = 0;
                else if (run_toggle)     nst = (st == 1) ? 0 : 1;
                else                     nst = st;
                if (clr) run_ph = 0;
                if (clr || (nst == 2 && st != 2)) adj_ph = 0;
                st = nst;
                e.st = 2'(st);
            end
            exp_q.push_back(e);
        end
    end

    // monitor: every registered output vector is compared half a cycle after the edge
    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = sample();
                check("cycle", a, e);
                if (a.t1 === 1'b1) seen_1hz++;
                if (a.ta === 1'b1) seen_adj++;
                if (a.ce === 1'b1) seen_ce++;
            end
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic c, input logic a_lvl);
        @(negedge clk);
        run_toggle = r; clr = c; adj = a_lvl;
        @(negedge clk);
        run_toggle = 1'b0; clr = 1'b0;
    endtask

    initial begin : stim
        int op, gap;
        idle(3);
        check("reset_state", sample(), '0);
        #3 rst_n = 1'b1;
        idle(4000);
        drive(1, 0, 0);
        idle(3500);
        drive(1, 0, 0);
        idle(300);
        drive(1, 0, 0);
        idle(1500);
        drive(0, 0, 1);
        idle(1600);
        drive(0, 0, 0);
        idle(800);
        drive(1, 0, 0);
        idle(1300);
        drive(1, 1, 0);
        idle(500);
        drive(1, 0, 0);
        idle(1200);
        drive(1, 0, 1);
        idle(700);
        drive(0, 1, 1);
        idle(600);
        drive(0, 0, 0);
        idle(50);
        for (int i = 0; i < 30; i++) begin
            op  = $urandom_range(0, 5);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 1200);
            case (op)
                0: drive(1, 0, adj);
                1: drive(0, 1, adj);
                2: drive(1, 1, adj);
                3: drive(0, 0, 1);
                4: drive(0, 0, 0);
                default: drive(1, 0, ~adj);
            endcase
            idle(gap);
        end
        drive(0, 0, 0);
        drive(1, 0, 0);
        idle(1700);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset", sample(), '0);
        idle(2);
        #3 rst_n = 1'b1;
        drive(1, 0, 0);
        idle(1100);
        check_seen("tick_1hz_seen", seen_1hz, 4);
        check_seen("tick_adj_seen", seen_adj, 2);
        check_seen("count_en_seen", seen_ce, 6);
        @(negedge clk);
        #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
